sync_pgen_multi: RTL and testbench
==================================

Name: sync_pgen_multi

Overview:
- Multi-channel successor to the single-bit synchronized pulse generator.
- Each channel:
  - brings an asynchronous, register-driven level into the out_clock domain through a parametrised synchronizer chain;
  - detects rising, falling or both edges, selected per channel;
  - emits a one-cycle edge strobe and a stretched pulse of programmable length.
- Sits at the boundary between external trigger/status inputs and the sequencer/timing logic.
- Flags edges that arrive while the previous pulse is still active.

Parameters:
- CHANNELS, 4: number of independent channels (1-32).
- SYNC, 2: synchronizer stages per channel (2-3).
- PWIDTH, 8: width of pulse_len and of each per-channel stretch counter.
- CWIDTH, 16: width of each per-channel event counter (used only with the optional feature).

Ports:
- out_clock  in  1  destination-domain clock; all logic on the rising edge.
- out_reset  in  1  synchronous, active-high reset.
- in_signal  in  CHANNELS  asynchronous levels; each must come from a register in its source domain.
- mode  in  2*CHANNELS  per-channel edge select, channel i at bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
- pulse_len  in  PWIDTH  stretched-pulse length in cycles; shared by all channels; 0 is treated as 1.
- clear_overrun  in  CHANNELS  per-channel clear of the sticky overrun flag.
- out_signal  out  CHANNELS  synchronized, registered copy of in_signal.
- out_edge  out  CHANNELS  one-cycle strobe per qualified edge.
- out_pulse  out  CHANNELS  stretched pulse.
- out_overrun  out  CHANNELS  sticky: a qualified edge arrived while out_pulse was active.

Behaviour:
- Reset:
  - out_reset=1 at a clock edge clears all synchronizer stages, out_signal, out_edge, out_pulse, out_overrun, stretch counters and event counters to 0.
  - The same values apply as power-up initial values.
  - Reset mid-pulse aborts the pulse immediately; there is no partial pulse after reset release.
- Synchronizer:
  - Per channel, shift register sync[SYNC-1:0] with ASYNC_REG attribute; sync[0] samples in_signal.
  - in_sync = sync[SYNC-1].
- Latency: in_signal first sampled high at edge n:
  - in_sync high after edge n+SYNC-1;
  - out_signal high after edge n+SYNC.
- Edge qualification (combinational):
  - rise = in_sync & ~out_signal; fall = ~in_sync & out_signal.
  - qual = (mode[0] & rise) | (mode[1] & fall).
- out_edge:
  - Registered qual: high after edge n+SYNC for exactly one cycle.
  - Same cycle that out_signal changes.
- mode is sampled each cycle and takes effect on the next edge.
- mode=00: out_signal still tracks the input; out_edge, out_pulse and overrun remain 0.
- Per-channel pulse state machine:
  - IDLE: on qual, load counter = max(pulse_len,1)-1, set out_pulse=1, go to ACTIVE.
    - out_pulse rises on the same edge as out_edge.
  - ACTIVE: counter==0 -> out_pulse=0, go to IDLE; otherwise counter decrements.
    - A qual while ACTIVE does not retrigger or extend the pulse.
    - It sets out_overrun.
    - It still produces out_edge.
  - Result: out_pulse is high for exactly max(pulse_len,1) cycles.
  - A qual in the same cycle that counter reaches 0 is treated as arriving in ACTIVE: overrun is set and no new pulse starts.
- pulse_len is sampled only on the IDLE->ACTIVE transition; later changes do not affect a running pulse.
- out_overrun:
  - Set by an overrun event; cleared by clear_overrun[i].
  - Simultaneous set and clear: set wins.
- Channels are fully independent; no cross-channel ordering is guaranteed beyond the synchronizer.

Optional Feature:
- Macro: SYNC_PGEN_MULTI_COUNT_EN.
- Defined:
  - adds input count_clear (CHANNELS);
  - adds output out_count (CHANNELS*CWIDTH), channel i at bits [CWIDTH*(i+1)-1:CWIDTH*i];
  - each counter increments on every out_edge and saturates at all ones;
  - count_clear[i] has priority: counter goes to 0 and a coincident edge is not counted;
  - counters reset to 0.
- Undefined: the ports and counters do not exist.

Test Plan:
- SYNC=2, mode=01, pulse_len=3, ch0 in_signal 0->1 before edge n:
  - out_signal and out_edge high after edge n+2;
  - out_edge low after n+3;
  - out_pulse high for cycles n+2..n+4 only.
- mode=10 vs 11, toggling input with 10-cycle spacing:
  - falling-only gives one out_edge per 1->0 transition;
  - both gives one out_edge per transition;
  - mode=00 gives none, while out_signal still follows the input.
- pulse_len=8, second qualified edge 4 cycles after the first:
  - pulse stays exactly 8 cycles;
  - out_overrun=1 and sticky;
  - clear_overrun asserted together with a third overrun edge leaves it 1;
  - clear_overrun alone clears it.
- pulse_len=0: out_pulse is high for exactly 1 cycle; pulse_len changed from 5 to 2 mid-pulse: pulse still lasts 5 cycles.
- out_reset asserted for 1 cycle during an active pulse on all 4 channels: every output is 0 after that edge, and no pulse resumes after reset release.
- SYNC_PGEN_MULTI_COUNT_EN, CWIDTH=2: 5 edges give out_count=3 (saturated); count_clear coincident with an edge gives 0.

Source files
------------

// File: rtl/sync_pgen_multi.sv
// Multi-channel synchronized edge detector with stretched pulse and overrun flag.
// Optional per-channel saturating event counters under SYNC_PGEN_MULTI_COUNT_EN.
module sync_pgen_multi #(
  parameter int CHANNELS = 4,
  parameter int SYNC     = 2,
  parameter int PWIDTH   = 8,
  parameter int CWIDTH   = 16
) (
  input  logic                         out_clock,
  input  logic                         out_reset,
  input  logic [CHANNELS-1:0]          in_signal,
  input  logic [2*CHANNELS-1:0]        mode,
  input  logic [PWIDTH-1:0]            pulse_len,
  input  logic [CHANNELS-1:0]          clear_overrun,
`ifdef SYNC_PGEN_MULTI_COUNT_EN
  input  logic [CHANNELS-1:0]          count_clear,
  output logic [CHANNELS*CWIDTH-1:0]   out_count,
`endif
  output logic [CHANNELS-1:0]          out_signal,
  output logic [CHANNELS-1:0]          out_edge,
  output logic [CHANNELS-1:0]          out_pulse,
  output logic [CHANNELS-1:0]          out_overrun
);

  localparam logic IDLE   = 1'b0;
  localparam logic ACTIVE = 1'b1;

  if (CHANNELS < 1 || CHANNELS > 32 || SYNC < 2 || SYNC > 3 ||
      PWIDTH < 1 || CWIDTH < 1) begin : g_bad_param
    $error("sync_pgen_multi: parameter out of range");
  end

  // Zero length behaves as one cycle.
  logic [PWIDTH-1:0] load_val;
  assign load_val = (pulse_len == '0) ? '0 : pulse_len - PWIDTH'(1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    (* ASYNC_REG = "TRUE" *) logic [SYNC-1:0] sync_q;
    logic              sig_q;
    logic              edge_q;
    logic              state_q, state_d;
    logic              ovr_q, ovr_d;
    logic [PWIDTH-1:0] cnt_q, cnt_d;
    logic              in_sync;
    logic              rise;
    logic              fall;
    logic              qual;

    assign in_sync = sync_q[SYNC-1];
    assign rise    = in_sync & ~sig_q;
    assign fall    = ~in_sync & sig_q;
    assign qual    = (mode[2*i] & rise) | (mode[2*i+1] & fall);

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ovr_d   = ovr_q;
      if (clear_overrun[i]) ovr_d = 1'b0;
      if (state_q == IDLE) begin
        if (qual) begin
          state_d = ACTIVE;
          cnt_d   = load_val;
        end
      end else begin
        if (qual) ovr_d = 1'b1;
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - PWIDTH'(1);
      end
    end

    always_ff @(posedge out_clock) begin
      if (out_reset) begin
        sync_q  <= '0;
        sig_q   <= 1'b0;
        edge_q  <= 1'b0;
        state_q <= IDLE;
        cnt_q   <= '0;
        ovr_q   <= 1'b0;
      end else begin
        sync_q  <= {sync_q[SYNC-2:0], in_signal[i]};
        sig_q   <= in_sync;
        edge_q  <= qual;
        state_q <= state_d;
        cnt_q   <= cnt_d;
        ovr_q   <= ovr_d;
      end
    end

    assign out_signal[i]  = sig_q;
    assign out_edge[i]    = edge_q;
    assign out_pulse[i]   = state_q;
    assign out_overrun[i] = ovr_q;

`ifdef SYNC_PGEN_MULTI_COUNT_EN
    logic [CWIDTH-1:0] evc_q, evc_d;

    // Counts on the same edge that raises out_edge; clear wins.
    always_comb begin
      evc_d = evc_q;
      if (count_clear[i])           evc_d = '0;
      else if (qual && evc_q != '1) evc_d = evc_q + CWIDTH'(1);
    end

    always_ff @(posedge out_clock) begin
      if (out_reset) evc_q <= '0;
      else           evc_q <= evc_d;
    end

    assign out_count[CWIDTH*i +: CWIDTH] = evc_q;
`endif
  end

endmodule

// File: tb/tb_sync_pgen_multi.sv
// Directed bench for sync_pgen_multi: vector table plus corner sequences.
// Count checks build only with SYNC_PGEN_MULTI_COUNT_EN.
module tb_sync_pgen_multi;
  localparam int CH = 4;
`ifdef SYNC_PGEN_MULTI_COUNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif

  logic            clk;
  logic            rst;
  logic [CH-1:0]   in_s;
  logic [2*CH-1:0] mode;
  logic [7:0]      plen;
  logic [CH-1:0]   clr;
  logic [CH-1:0]   sig, edg, pul, ovr;
`ifdef SYNC_PGEN_MULTI_COUNT_EN
  logic [CH-1:0]   cclr;
  logic [CH*CW-1:0] cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  sync_pgen_multi #(
    .CHANNELS(CH), .SYNC(2), .PWIDTH(8), .CWIDTH(CW)
  ) dut (
    .out_clock    (clk),
    .out_reset    (rst),
    .in_signal    (in_s),
    .mode         (mode),
    .pulse_len    (plen),
    .clear_overrun(clr),
`ifdef SYNC_PGEN_MULTI_COUNT_EN
    .count_clear  (cclr),
    .out_count    (cnt),
`endif
    .out_signal   (sig),
    .out_edge     (edg),
    .out_pulse    (pul),
    .out_overrun  (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] in;
    logic [3:0] sig;
    logic [3:0] edg;
    logic [3:0] pul;
  } vec_t;

  vec_t tbl [26];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    in_s = '0;
    clr  = '0;
`ifdef SYNC_PGEN_MULTI_COUNT_EN
    cclr = '0;
`endif
    repeat (3) tick();
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    in_s = '0;
    mode = '0;
    plen = 8'd3;
    clr  = '0;
`ifdef SYNC_PGEN_MULTI_COUNT_EN
    cclr = '0;
`endif
    // ch0 rise, ch1 fall, ch2 both, ch3 off; pulse_len 3
    tbl[0]  = '{4'hF, 4'h0, 4'h0, 4'h0};
    tbl[1]  = '{4'hF, 4'h0, 4'h0, 4'h0};
    tbl[2]  = '{4'hF, 4'hF, 4'h5, 4'h5};
    tbl[3]  = '{4'hF, 4'hF, 4'h0, 4'h5};
    tbl[4]  = '{4'hF, 4'hF, 4'h0, 4'h5};
    tbl[5]  = '{4'hF, 4'hF, 4'h0, 4'h0};
    tbl[6]  = '{4'hF, 4'hF, 4'h0, 4'h0};
    tbl[7]  = '{4'hF, 4'hF, 4'h0, 4'h0};
    tbl[8]  = '{4'hF, 4'hF, 4'h0, 4'h0};
    tbl[9]  = '{4'hF, 4'hF, 4'h0, 4'h0};
    tbl[10] = '{4'h0, 4'hF, 4'h0, 4'h0};
    tbl[11] = '{4'h0, 4'hF, 4'h0, 4'h0};
    tbl[12] = '{4'h0, 4'h0, 4'h6, 4'h6};
    tbl[13] = '{4'h0, 4'h0, 4'h0, 4'h6};
    tbl[14] = '{4'h0, 4'h0, 4'h0, 4'h6};
    tbl[15] = '{4'h0, 4'h0, 4'h0, 4'h0};
    tbl[16] = '{4'h0, 4'h0, 4'h0, 4'h0};
    tbl[17] = '{4'h0, 4'h0, 4'h0, 4'h0};
    tbl[18] = '{4'h0, 4'h0, 4'h0, 4'h0};
    tbl[19] = '{4'h0, 4'h0, 4'h0, 4'h0};
    tbl[20] = '{4'hF, 4'h0, 4'h0, 4'h0};
    tbl[21] = '{4'hF, 4'h0, 4'h0, 4'h0};
    tbl[22] = '{4'hF, 4'hF, 4'h5, 4'h5};
    tbl[23] = '{4'hF, 4'hF, 4'h0, 4'h5};
    tbl[24] = '{4'hF, 4'hF, 4'h0, 4'h5};
    tbl[25] = '{4'hF, 4'hF, 4'h0, 4'h0};

    do_reset();
    chk("rst sig", 32'(sig), 32'h0);
    chk("rst edge", 32'(edg), 32'h0);
    chk("rst pulse", 32'(pul), 32'h0);
    chk("rst ovr", 32'(ovr), 32'h0);

    mode = 8'h39;
    plen = 8'd3;
    tick();
    for (int i = 0; i < 26; i++) begin
      in_s = tbl[i].in;
      tick();
      chk($sformatf("tbl%0d sig", i), 32'(sig), 32'(tbl[i].sig));
      chk($sformatf("tbl%0d edge", i), 32'(edg), 32'(tbl[i].edg));
      chk($sformatf("tbl%0d pulse", i), 32'(pul), 32'(tbl[i].pul));
      chk($sformatf("tbl%0d ovr", i), 32'(ovr), 32'h0);
    end

    // Overrun: len 8, second edge 4 cycles in, set/clear priority
    do_reset();
    mode = 8'h03;
    plen = 8'd8;
    for (int k = 0; k < 28; k++) begin
      in_s[0] = (k < 4) ? 1'b1 : (k < 12) ? 1'b0 : (k < 16) ? 1'b1 : 1'b0;
      clr[0]  = (k == 11 || k == 18 || k == 25);
      tick();
      chk($sformatf("ovr k%0d pulse", k), 32'(pul[0]),
          32'((k >= 2 && k <= 9) || (k >= 14 && k <= 21)));
      chk($sformatf("ovr k%0d edge", k), 32'(edg[0]),
          32'(k == 2 || k == 6 || k == 14 || k == 18));
      chk($sformatf("ovr k%0d flag", k), 32'(ovr[0]),
          32'((k >= 6 && k <= 10) || (k >= 18 && k <= 24)));
    end
    clr = '0;

    // Zero pulse length gives one cycle
    do_reset();
    mode = 8'h01;
    plen = 8'd0;
    for (int k = 0; k < 6; k++) begin
      in_s[0] = 1'b1;
      tick();
      chk($sformatf("len0 k%0d", k), 32'(pul[0]), 32'(k == 2));
    end

    // Length change mid-pulse is ignored
    in_s[0] = 1'b0;
    repeat (5) tick();
    plen = 8'd5;
    for (int k = 0; k < 10; k++) begin
      in_s[0] = 1'b1;
      if (k == 3) plen = 8'd2;
      tick();
      chk($sformatf("len5 k%0d", k), 32'(pul[0]), 32'(k >= 2 && k <= 6));
    end

    // Reset during active pulses on all channels
    do_reset();
    mode = 8'h55;
    plen = 8'd8;
    for (int k = 0; k < 4; k++) begin
      in_s = 4'hF;
      tick();
      if (k >= 2) chk($sformatf("pre k%0d", k), 32'(pul), 32'hF);
    end
    rst  = 1'b1;
    in_s = 4'h0;
    tick();
    rst = 1'b0;
    chk("mid rst sig", 32'(sig), 32'h0);
    chk("mid rst edge", 32'(edg), 32'h0);
    chk("mid rst pulse", 32'(pul), 32'h0);
    chk("mid rst ovr", 32'(ovr), 32'h0);
    for (int k = 5; k < 15; k++) begin
      tick();
      chk($sformatf("post k%0d", k), 32'(pul | edg | sig), 32'h0);
    end

`ifdef SYNC_PGEN_MULTI_COUNT_EN
    do_reset();
    mode = 8'h03;
    plen = 8'd1;
    chk("cnt rst", 32'(cnt[CW-1:0]), 32'h0);
    for (int k = 0; k < 20; k++) begin
      in_s[0] = ((k / 4) % 2 == 0);
      tick();
    end
    repeat (4) tick();
    chk("cnt sat", 32'(cnt[CW-1:0]), 32'h3);
    in_s[0] = 1'b0;
    tick();
    tick();
    cclr[0] = 1'b1;
    tick();
    cclr[0] = 1'b0;
    chk("cnt clr edge", 32'(edg[0]), 32'h1);
    chk("cnt clr", 32'(cnt[CW-1:0]), 32'h0);
    tick();
    chk("cnt after clr", 32'(cnt[CW-1:0]), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
